// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor (a - b), one digit per clock, LSD first, with registered borrow.
// Define SIGN_MAG_EN to get sign-magnitude results (|a-b| plus neg) instead of ten's complement.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] diff,
    output logic                borrow,
    output logic                neg,
    output logic                err,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
`ifdef SIGN_MAG_EN
        S_NEGATE,
`endif
        S_DONE
    } state_t;

    state_t              state_q;
    logic [4*DIGITS-1:0] a_q, b_q, diff_q, diff_d;
    logic [CNT_W-1:0]    idx_q;
    logic                bq_q, bq_d;
    logic                borrow_q, err_q, busy_q, done_q;
    logic [DIGITS-1:0]   bad_dig;
    logic [3:0]          x_dig, y_dig, dig;
    logic [4:0]          t_diff;
    logic                last_dig;

    // Operand digit selection; NEGATE subtracts the stored result from zero.
    always_comb begin
        x_dig = 4'd0;
        y_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == CNT_W'(i)) begin
`ifdef SIGN_MAG_EN
                if (state_q == S_NEGATE) begin
                    y_dig = diff_q[4*i +: 4];
                end else begin
                    x_dig = a_q[4*i +: 4];
                    y_dig = b_q[4*i +: 4];
                end
`else
                x_dig = a_q[4*i +: 4];
                y_dig = b_q[4*i +: 4];
`endif
            end
        end
    end

    // 5-bit two's complement: bit 4 is the sign, so a negative digit borrows and gets +10.
    assign t_diff   = {1'b0, x_dig} - {1'b0, y_dig} - {4'd0, bq_q};
    assign bq_d     = t_diff[4];
    assign dig      = t_diff[4] ? (t_diff[3:0] + 4'd10) : t_diff[3:0];
    assign last_dig = (idx_q == CNT_W'(DIGITS - 1));

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            assign bad_dig[gi] = (a_q[4*gi +: 4] > 4'd9) || (b_q[4*gi +: 4] > 4'd9);
            assign diff_d[4*gi +: 4] = (idx_q == CNT_W'(gi)) ? dig : diff_q[4*gi +: 4];
        end
    endgenerate

`ifdef SIGN_MAG_EN
    logic neg_q;
    assign neg = neg_q;
`else
    assign neg = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            bq_q     <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SIGN_MAG_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        diff_q   <= '0;
                        borrow_q <= 1'b0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef SIGN_MAG_EN
                        neg_q    <= 1'b0;
`endif
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (|bad_dig) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= '0;
                        bq_q    <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    diff_q <= diff_d;
                    bq_q   <= bq_d;
                    if (last_dig) begin
                        idx_q    <= '0;
                        borrow_q <= bq_d;
`ifdef SIGN_MAG_EN
                        if (bq_d) begin
                            bq_q    <= 1'b0;
                            state_q <= S_NEGATE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
`else
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`endif
                    end else begin
                        idx_q <= idx_q + CNT_W'(1);
                    end
                end
`ifdef SIGN_MAG_EN
                S_NEGATE: begin
                    diff_q <= diff_d;
                    bq_q   <= bq_d;
                    if (last_dig) begin
                        idx_q   <= '0;
                        neg_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + CNT_W'(1);
                    end
                end
`endif
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Bench for bcd_serial_subtractor: decimal-arithmetic reference model, per-cycle compare, directed and random runs.
module tb_bcd_serial_subtractor;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] diff;
    logic         borrow, neg, err, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state: what the outputs must show after each rising edge.
    logic         m_busy = 1'b0, m_done = 1'b0, m_borrow = 1'b0, m_neg = 1'b0, m_err = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         p_borrow = 1'b0, p_neg = 1'b0, p_err = 1'b0;
    logic [W-1:0] p_diff = '0;
    int           done_cyc = 0;
    int           m_lat = 0;

    bcd_serial_subtractor #(.DIGITS(D), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .diff(diff), .borrow(borrow), .neg(neg), .err(err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic bit bcd_ok(input logic [W-1:0] v);
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        longint t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 11) == 0) r[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    task automatic predict(input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
        longint d, p10;
        p10 = 1;
        for (int i = 0; i < D; i++) p10 = p10 * 10;
        p_diff = '0; p_borrow = 1'b0; p_neg = 1'b0; p_err = 1'b0;
        if (!bcd_ok(x) || !bcd_ok(y)) begin
            p_err = 1'b1;
            lat = 2;
        end else begin
            d = bcd2int(x) - bcd2int(y);
            lat = D + 2;
            if (d >= 0) begin
                p_diff = int2bcd(d);
            end else begin
                p_borrow = 1'b1;
`ifdef SIGN_MAG_EN
                p_diff = int2bcd(-d);
                p_neg = 1'b1;
                lat = 2 * D + 2;
`else
                p_diff = int2bcd(p10 + d);
`endif
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_diff = '0;
            m_borrow = 1'b0; m_neg = 1'b0; m_err = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (cyc == done_cyc) begin
                m_diff = p_diff; m_borrow = p_borrow; m_neg = p_neg; m_err = p_err;
                m_done = 1'b1;
            end
        end else if (start) begin
            predict(a, b, m_lat);
            m_busy = 1'b1; m_diff = '0; m_borrow = 1'b0; m_neg = 1'b0; m_err = 1'b0;
            done_cyc = cyc + m_lat - 1;
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model; results only while idle or in the done cycle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("busy", W'(busy), W'(m_busy));
            chk("done", W'(done), W'(m_done));
            if (!m_busy || m_done) begin
                chk("diff", diff, m_diff);
                chk("borrow", W'(borrow), W'(m_borrow));
                chk("neg", W'(neg), W'(m_neg));
                chk("err", W'(err), W'(m_err));
            end
        end
    end

    task automatic wait_done(input string nm, input int n0, output int n, output bit ok);
        n = n0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = done;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout cyc=%0d got=no_done want=done", nm, cyc);
        end
    endtask

    task automatic directed(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] e_diff, input logic e_b, input logic e_n,
                            input logic e_e, input int e_lat);
        int n;
        bit ok;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        wait_done(nm, 1, n, ok);
        if (ok) begin
            chk({nm, "_lat"}, W'(n), W'(e_lat));
            chk({nm, "_diff"}, diff, e_diff);
            chk({nm, "_borrow"}, W'(borrow), W'(e_b));
            chk({nm, "_neg"}, W'(neg), W'(e_n));
            chk({nm, "_err"}, W'(err), W'(e_e));
        end
        $display("txn %s a=%h b=%h diff=%h borrow=%b neg=%b err=%b lat=%0d", nm, x, y, diff, borrow, neg, err, n);
    endtask

    initial begin
        int n;
        bit ok;
        bit saw;
        repeat (2) @(negedge clk);
        chk("rst_diff", diff, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        rst = 1'b0;

        directed("basic", 16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 1'b0, 6);
        @(negedge clk);
        chk("busy_after", W'(busy), '0);
        directed("ripple", 16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0, 1'b0, 6);
`ifdef SIGN_MAG_EN
        directed("negative", 16'h0005, 16'h0010, 16'h0005, 1'b1, 1'b1, 1'b0, 10);
`else
        directed("negative", 16'h0005, 16'h0010, 16'h9995, 1'b1, 1'b0, 1'b0, 6);
`endif
        directed("bad_digit", 16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 2);
        directed("equal", 16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 1'b0, 6);

        // Second start while busy must be ignored.
        @(negedge clk);
        a = 16'h4321; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start", 3, n, ok);
        if (ok) chk("ignore_start_diff", diff, 16'h3210);
        $display("txn ignore_start a=4321 b=1111 diff=%h", diff);

        // Reset mid-run abandons the operation without a done pulse.
        @(negedge clk);
        @(negedge clk);
        a = 16'h1234; b = 16'h0567; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_diff", diff, '0);
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk("abort_no_done", W'(saw), '0);
        $display("txn abort_by_reset done_seen=%b", saw);
        directed("after_reset", 16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 1'b0, 6);

        // Random traffic: starts at arbitrary times (often while busy), equal operands, bad digits, resets.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (done) $display("txn rand diff=%h borrow=%b neg=%b err=%b", diff, borrow, neg, err);
            start = ($urandom_range(0, 3) == 0);
            a = rnd_bcd();
            b = ($urandom_range(0, 7) == 0) ? a : rnd_bcd();
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
